// File: rtl/ias_pkg.sv
// Shared IAS definitions: word widths, store FSM state encoding and store error causes.
package ias_pkg;

  localparam int IAS_DATA_W = 8;
  localparam int IAS_ADDR_W = 8;

  // ST_DONE is held back for masters that need an explicit completion state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } store_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_MISMATCH = 2'd2
  } store_err_t;

  function automatic logic is_err(store_err_t cause);
    return cause != ERR_NONE;
  endfunction

endpackage

// File: rtl/mem_ack_timer.sv
// Saturating wait-state counter for memory-side masters; expired flags the
// TIMEOUT-th enabled cycle since the last clear.
module mem_ack_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] SAT  = TW'(TIMEOUT);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      count <= '0;
    else if (clear)                 count <= '0;
    else if (enable && count != SAT) count <= count + TW'(1);
  end

  // count holds the number of earlier enabled cycles, so LAST marks the final allowed one
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/ac_store_unit.sv
// Accumulator write-back master: captures ac_data/store_addr on store_req and writes
// them over a req/ack memory port. Optional readback verify: AC_STORE_READBACK_EN.
module ac_store_unit
  import ias_pkg::*;
#(
  parameter int DATA_W  = IAS_DATA_W,
  parameter int ADDR_W  = IAS_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [DATA_W-1:0] ac_data,
  output logic              store_busy,
  output logic              store_done,
  output logic              store_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  store_state_t state, state_n;
  store_err_t   cause;
  logic         done_n, capture;
  logic         tmr_clr, tmr_en, tmr_exp;

  mem_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .expired (tmr_exp)
  );

  assign store_busy = (state != ST_IDLE);
  assign mem_we     = (state == ST_WRITE);

`ifdef AC_STORE_READBACK_EN
  // The write ack may still be asserted on the first READ cycle, so only
  // acks from the second READ cycle onward complete the readback.
  logic rd_armed;
  assign mem_re = (state == ST_READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_armed <= 1'b0;
    else       rd_armed <= (state == ST_READ);
  end
`else
  logic unused_rdata;
  assign mem_re       = 1'b0;
  assign unused_rdata = ^mem_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      store_done <= 1'b0;
      store_err  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      store_done <= done_n;
      store_err  <= is_err(cause);
      if (capture) begin
        mem_addr  <= store_addr;
        mem_wdata <= ac_data;
      end
    end
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    cause   = ERR_NONE;
    capture = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (store_req) begin
          capture = 1'b1;
          state_n = ST_WRITE;
        end
      end
      ST_WRITE: begin
        tmr_en = 1'b1;
        // ack is checked before expiry so a same-cycle ack still succeeds
        if (mem_ack) begin
          tmr_clr = 1'b1;
`ifdef AC_STORE_READBACK_EN
          state_n = ST_READ;
`else
          state_n = ST_IDLE;
          done_n  = 1'b1;
`endif
        end else if (tmr_exp) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          cause   = ERR_TIMEOUT;
        end
      end
      ST_READ: begin
`ifdef AC_STORE_READBACK_EN
        tmr_en = 1'b1;
        if (mem_ack && rd_armed) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          if (mem_rdata != mem_wdata) cause = ERR_MISMATCH;
        end else if (tmr_exp) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          cause   = ERR_TIMEOUT;
        end
`else
        state_n = ST_IDLE;
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
